// File: rtl/expr_eval_pkg.sv
// Shared definitions for the ASCII expression recognizer/evaluator family:
// FSM state codes, operator codes and the character constants both blocks decode.
package expr_eval_pkg;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_NUM   = 2'd1,
    S_OP    = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  typedef enum logic {
    ADD = 1'b0,
    MUL = 1'b1
  } op_t;

  localparam logic [7:0] CH_0    = 8'h30;  // "0"
  localparam logic [7:0] CH_9    = 8'h39;  // "9"
  localparam logic [7:0] CH_PLUS = 8'h2B;  // "+"
  localparam logic [7:0] CH_MUL  = 8'h2A;  // "*"

endpackage

// File: rtl/expr_eval_if.sv
// Byte-stream bus shared by the recognizer and evaluator, plus the evaluator's
// result outputs. The ovf signal exists only when EXPR_OVF_EN is defined.
interface expr_eval_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic [7:0]   in;
  logic [W-1:0] result;
  logic         legal;
`ifdef EXPR_OVF_EN
  logic         ovf;

  modport master (output in_valid, in, input result, legal, ovf);
  modport slave  (input in_valid, in, output result, legal, ovf);
`else
  modport master (output in_valid, in, input result, legal);
  modport slave  (input in_valid, in, output result, legal);
`endif
endinterface

// File: rtl/expr_char_dec.sv
// Classifies one ASCII character as digit / plus / multiply and extracts the
// digit value. Purely combinational.
module expr_char_dec
  import expr_eval_pkg::*;
(
  input  logic [7:0] in,
  output logic       is_digit,
  output logic       is_plus,
  output logic       is_mul,
  output logic [3:0] value
);

  assign is_digit = (in >= CH_0) && (in <= CH_9);
  assign is_plus  = (in == CH_PLUS);
  assign is_mul   = (in == CH_MUL);
  // ASCII digits 0x30..0x39 carry their value in the low nibble.
  assign value    = is_digit ? in[3:0] : 4'd0;

endmodule

// File: rtl/expr_eval.sv
// On-the-fly evaluator for "digit (op digit)*" streams with '*' binding tighter
// than '+'. Optional sticky overflow flag when EXPR_OVF_EN is defined.
module expr_eval
  import expr_eval_pkg::*;
#(
  parameter int W = 16
) (
  input  logic        clk,
  input  logic        clr,
  expr_eval_if.slave  bus
);

  logic         is_digit, is_plus, is_mul;
  logic [3:0]   value;
  logic [W-1:0] value_w;

  state_t       state, state_nx;
  op_t          last_op, last_op_nx;
  logic [W-1:0] sum, sum_nx;
  logic [W-1:0] term, term_nx;
  logic [W-1:0] sum_term;
  logic [W-1:0] prod;

  expr_char_dec u_dec (
    .in       (bus.in),
    .is_digit (is_digit),
    .is_plus  (is_plus),
    .is_mul   (is_mul),
    .value    (value)
  );

  assign value_w = {{(W-4){1'b0}}, value};

`ifdef EXPR_OVF_EN
  logic         ovf, ovf_nx;
  logic [W:0]   sum_term_x;
  logic [2*W-1:0] prod_x;

  // Full-precision copies so the carry / upper product half reveal wrap-around.
  assign sum_term_x = {1'b0, sum} + {1'b0, term};
  assign prod_x     = {{W{1'b0}}, term} * {{(2*W-4){1'b0}}, value};
  assign sum_term   = sum_term_x[W-1:0];
  assign prod       = prod_x[W-1:0];

  always_comb begin
    ovf_nx = ovf;
    if (bus.in_valid) begin
      if (state == S_NUM && sum_term_x[W])
        ovf_nx = 1'b1;
      if (state == S_OP && is_digit && last_op == MUL && (|prod_x[2*W-1:W]))
        ovf_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) ovf <= 1'b0;
    else      ovf <= ovf_nx;
  end

  assign bus.ovf = ovf;
`else
  assign sum_term = sum + term;
  assign prod     = term * value_w;
`endif

  // NOTE: every variable gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nx   = state;
    sum_nx     = sum;
    term_nx    = term;
    last_op_nx = last_op;
    if (bus.in_valid) begin
      unique case (state)
        S_START: begin
          if (is_digit) begin
            term_nx  = value_w;
            sum_nx   = '0;
            state_nx = S_NUM;
          end else begin
            state_nx = S_ERR;
          end
        end
        S_NUM: begin
          if (is_plus) begin
            sum_nx     = sum_term;
            last_op_nx = ADD;
            state_nx   = S_OP;
          end else if (is_mul) begin
            last_op_nx = MUL;
            state_nx   = S_OP;
          end else begin
            state_nx = S_ERR;
          end
        end
        S_OP: begin
          if (is_digit) begin
            term_nx  = (last_op == MUL) ? prod : value_w;
            state_nx = S_NUM;
          end else begin
            state_nx = S_ERR;
          end
        end
        S_ERR: state_nx = S_ERR;
        default: state_nx = S_ERR;
      endcase
    end
  end

  // NOTE: reset is synchronous (sampled on the clock edge) and all state uses
  // non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state   <= S_START;
      sum     <= '0;
      term    <= '0;
      last_op <= ADD;
    end else begin
      state   <= state_nx;
      sum     <= sum_nx;
      term    <= term_nx;
      last_op <= last_op_nx;
    end
  end

  assign bus.legal  = (state == S_NUM);
  assign bus.result = (state == S_NUM) ? sum_term : '0;

endmodule

// File: tb/tb_expr_eval.sv
// Self-checking bench for expr_eval: W=16 and W=8 instances share one stimulus
// stream; directed table, hand-written corner sequences and a random run.
module tb_expr_eval;

  logic clk;
  logic clr;

  expr_eval_if #(.W(16)) if16 ();
  expr_eval_if #(.W(8))  if8  ();

  expr_eval #(.W(16)) u16 (.clk(clk), .clr(clr), .bus(if16));
  expr_eval #(.W(8))  u8  (.clk(clk), .clr(clr), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (string level) ----------------
  byte q[$];          // characters accepted since reset (all well-placed)
  bit  m_err;
  bit  m_ovf[2];      // index 0: W=16, index 1: W=8
  int  widths[2] = '{16, 8};

  function automatic longint mask(input int w);
    return (64'd1 << w) - 1;
  endfunction

  function automatic bit is_dig(input byte c);
    return (c >= "0") && (c <= "9");
  endfunction

  // Split the accepted string into '+'-separated products; sum holds the
  // completed terms, term the product of the term still being built.
  function automatic void eval_q(input int w, output longint s, output longint t);
    bit mulp = 0;
    s = 0; t = 0;
    foreach (q[i]) begin
      if (is_dig(q[i])) begin
        t = mulp ? ((t * longint'(q[i] - "0")) & mask(w)) : longint'(q[i] - "0");
      end else if (q[i] == "+") begin
        s = (s + t) & mask(w);
        mulp = 0;
      end else begin
        mulp = 1;
      end
    end
  endfunction

  function automatic bit m_legal();
    return !m_err && (q.size() % 2 == 1);
  endfunction

  function automatic longint m_result(input int k);
    longint s, t;
    if (!m_legal()) return 0;
    eval_q(widths[k], s, t);
    return (s + t) & mask(widths[k]);
  endfunction

  task automatic model_reset();
    q.delete();
    m_err = 0;
    m_ovf[0] = 0;
    m_ovf[1] = 0;
  endtask

  task automatic model_accept(input byte c);
    longint s, t;
    int pos;
    bit ok;
    if (m_err) return;
    pos = q.size();
    for (int k = 0; k < 2; k++) begin
      eval_q(widths[k], s, t);
      if (m_legal() && (s + t) > mask(widths[k])) m_ovf[k] = 1;
      if (pos >= 2 && pos % 2 == 0 && q[pos-1] == "*" && is_dig(c) &&
          (t * longint'(c - "0")) > mask(widths[k]))
        m_ovf[k] = 1;
    end
    ok = (pos % 2 == 0) ? is_dig(c) : (c == "+" || c == "*");
    if (!ok) m_err = 1;
    else     q.push_back(c);
  endtask

  // One clock: inputs applied on the falling edge, outputs sampled 1 time unit
  // after the rising edge.
  task automatic drive(input bit c_n, input bit v, input byte ch);
    @(negedge clk);
    clr = c_n;
    if16.in_valid = v; if16.in = ch;
    if8.in_valid  = v; if8.in  = ch;
    @(posedge clk);
    #1;
    if (!c_n)   model_reset();
    else if (v) model_accept(ch);
  endtask

  task automatic check_model(input string tag);
    check({tag, " legal16"},  64'(if16.legal),  64'(m_legal()));
    check({tag, " result16"}, 64'(if16.result), 64'(m_result(0)));
    check({tag, " legal8"},   64'(if8.legal),   64'(m_legal()));
    check({tag, " result8"},  64'(if8.result),  64'(m_result(1)));
`ifdef EXPR_OVF_EN
    check({tag, " ovf16"}, 64'(if16.ovf), 64'(m_ovf[0]));
    check({tag, " ovf8"},  64'(if8.ovf),  64'(m_ovf[1]));
`endif
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit  clr_n;
    bit  vld;
    byte ch;
    bit  exp_legal;
    int  exp_res;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit c_n, input bit v, input byte ch, input bit l, input int r);
    vec_t x;
    x.clr_n = c_n; x.vld = v; x.ch = ch; x.exp_legal = l; x.exp_res = r;
    return x;
  endfunction

  function automatic byte pick_char();
    int r = $urandom_range(0, 9);
    byte c;
    if (r == 0) begin
      case ($urandom_range(0, 3))
        0: c = "x";
        1: c = " ";
        2: c = "+";
        default: c = 8'($urandom_range(48, 57));
      endcase
    end else if (q.size() % 2 == 0) begin
      c = 8'($urandom_range(48, 57));
    end else begin
      c = ($urandom_range(0, 1) == 1) ? "*" : "+";
    end
    return c;
  endfunction

  initial begin
    clr = 1'b0;
    if16.in_valid = 1'b0; if16.in = 8'h00;
    if8.in_valid  = 1'b0; if8.in  = 8'h00;
    model_reset();

    // "1+2*3"
    tbl.push_back(mk(0, 0, "0", 0, 0));
    tbl.push_back(mk(1, 1, "1", 1, 1));
    tbl.push_back(mk(1, 1, "+", 0, 0));
    tbl.push_back(mk(1, 1, "2", 1, 3));
    tbl.push_back(mk(1, 1, "*", 0, 0));
    tbl.push_back(mk(1, 1, "3", 1, 7));
    // "2*3+4*5"
    tbl.push_back(mk(0, 0, "0", 0, 0));
    tbl.push_back(mk(1, 1, "2", 1, 2));
    tbl.push_back(mk(1, 1, "*", 0, 0));
    tbl.push_back(mk(1, 1, "3", 1, 6));
    tbl.push_back(mk(1, 1, "+", 0, 0));
    tbl.push_back(mk(1, 1, "4", 1, 10));
    tbl.push_back(mk(1, 1, "*", 0, 0));
    tbl.push_back(mk(1, 1, "5", 1, 26));
    // "1++3" then more input, sticky error until reset
    tbl.push_back(mk(0, 0, "0", 0, 0));
    tbl.push_back(mk(1, 1, "1", 1, 1));
    tbl.push_back(mk(1, 1, "+", 0, 0));
    tbl.push_back(mk(1, 1, "+", 0, 0));
    tbl.push_back(mk(1, 1, "3", 0, 0));
    tbl.push_back(mk(1, 1, "4", 0, 0));
    tbl.push_back(mk(1, 1, "+", 0, 0));
    tbl.push_back(mk(1, 1, "5", 0, 0));
    tbl.push_back(mk(0, 1, "5", 0, 0));
    tbl.push_back(mk(1, 1, "5", 1, 5));
    // "1+2*3" with in_valid gaps carrying garbage
    tbl.push_back(mk(0, 0, "0", 0, 0));
    tbl.push_back(mk(1, 1, "1", 1, 1));
    tbl.push_back(mk(1, 0, "x", 1, 1));
    tbl.push_back(mk(1, 1, "+", 0, 0));
    tbl.push_back(mk(1, 0, "x", 0, 0));
    tbl.push_back(mk(1, 1, "2", 1, 3));
    tbl.push_back(mk(1, 0, "x", 1, 3));
    tbl.push_back(mk(1, 1, "*", 0, 0));
    tbl.push_back(mk(1, 1, "3", 1, 7));
    tbl.push_back(mk(1, 0, "x", 1, 7));
    // "9*", reset with a valid "7" in the same cycle, then "5"
    tbl.push_back(mk(0, 0, "0", 0, 0));
    tbl.push_back(mk(1, 1, "9", 1, 9));
    tbl.push_back(mk(1, 1, "*", 0, 0));
    tbl.push_back(mk(0, 1, "7", 0, 0));
    tbl.push_back(mk(1, 1, "5", 1, 5));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].clr_n, tbl[i].vld, tbl[i].ch);
      check($sformatf("tbl[%0d] legal16", i),  64'(if16.legal),  64'(tbl[i].exp_legal));
      check($sformatf("tbl[%0d] result16", i), 64'(if16.result), 64'(tbl[i].exp_res));
      check($sformatf("tbl[%0d] legal8", i),   64'(if8.legal),   64'(tbl[i].exp_legal));
      check($sformatf("tbl[%0d] result8", i),  64'(if8.result),  64'(tbl[i].exp_res));
    end

    // "9*9*9": wraps to 217 at W=8, exact 729 at W=16; ovf sticky through error
    drive(0, 0, "0");
    drive(1, 1, "9");
    drive(1, 1, "*");
    drive(1, 1, "9");
    check("999 r8 after 9*9", 64'(if8.result), 64'd81);
`ifdef EXPR_OVF_EN
    check("999 ovf8 after 9*9", 64'(if8.ovf), 64'd0);
`endif
    drive(1, 1, "*");
    drive(1, 1, "9");
    check("999 r8",  64'(if8.result),  64'd217);
    check("999 r16", 64'(if16.result), 64'd729);
`ifdef EXPR_OVF_EN
    check("999 ovf8",  64'(if8.ovf),  64'd1);
    check("999 ovf16", 64'(if16.ovf), 64'd0);
`endif
    drive(1, 1, "+");
    drive(1, 1, "1");
    check("999+1 r8", 64'(if8.result), 64'd218);
    drive(1, 1, "x");
    check("999 err legal8", 64'(if8.legal), 64'd0);
`ifdef EXPR_OVF_EN
    check("999 ovf8 in err", 64'(if8.ovf), 64'd1);
`endif
    drive(0, 0, "0");
    check("999 reset r8", 64'(if8.result), 64'd0);
`ifdef EXPR_OVF_EN
    check("999 ovf8 reset", 64'(if8.ovf), 64'd0);
`endif

    // Random stream against the string-level model
    drive(0, 0, "0");
    for (int i = 0; i < 600; i++) begin
      bit  c_n = ($urandom_range(0, 59) != 0);
      bit  v   = ($urandom_range(0, 4) != 0);
      byte c   = v ? pick_char() : 8'($urandom_range(0, 255));
      drive(c_n, v, c);
      check_model($sformatf("rnd[%0d]", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
